// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared opcode, width and group-state definitions for the RISC pipeline
package risc_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;
  localparam int REG_W  = 3;
  localparam int CNT_W  = 4;

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_SW = 4'b0101;
  localparam logic [3:0] OP_LM = 4'b1100;
  localparam logic [3:0] OP_SM = 4'b1101;

  // An LM/SM group may move at most one transfer per architectural register.
  localparam logic [CNT_W-1:0] GRP_MAX = 4'd8;

  typedef enum logic {
    IDLE  = 1'b0,
    GROUP = 1'b1
  } grp_state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LM);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SM);
  endfunction

  function automatic logic is_grp(input logic [3:0] op);
    return (op == OP_LM) || (op == OP_SM);
  endfunction

endpackage

// File: rtl/lmsm_mem_stage_if.sv
// rtl/lmsm_mem_stage_if.sv - data-memory port between the memory stage and the data RAM
interface lmsm_mem_stage_if #(
  parameter int AW = risc_pkg::AW_DEF,
  parameter int DW = risc_pkg::DW_DEF
);
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_we;
  logic [DW-1:0] dmem_rdata;

  modport master (
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    output dmem_rdata
  );
endinterface

// File: rtl/lmsm_grp_tracker.sv
// rtl/lmsm_grp_tracker.sv - LM/SM group boundary FSM: tags the closing transfer and flags broken groups
module lmsm_grp_tracker
  import risc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic [3:0]       opcode,
  input  logic             comp,
  output logic             tag_done,
  output logic [CNT_W-1:0] tag_cnt,
  output logic             seq_err
);

  grp_state_e       state, state_nx;
  logic [3:0]       grp_op, grp_op_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             err;
  logic             fresh;

  always_comb begin
    state_nx  = state;
    grp_op_nx = grp_op;
    cnt_nx    = cnt;
    tag_done  = 1'b0;
    tag_cnt   = '0;
    err       = 1'b0;
    fresh     = 1'b1;
    if (state == GROUP) begin
      if (opcode == grp_op && cnt < GRP_MAX) begin
        fresh = 1'b0;
        if (comp) begin
          tag_done = 1'b1;
          tag_cnt  = cnt + 4'd1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end else begin
        err      = 1'b1;
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    end
    // An offending micro-op falls through and is handled as if the FSM were idle.
    if (fresh && is_grp(opcode)) begin
      if (comp) begin
        tag_done = 1'b1;
        tag_cnt  = 4'd1;
      end else begin
        state_nx  = GROUP;
        grp_op_nx = opcode;
        cnt_nx    = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grp_op  <= '0;
      cnt     <= '0;
      seq_err <= 1'b0;
    end else begin
      seq_err <= accept && err;
      if (accept) begin
        state  <= state_nx;
        grp_op <= grp_op_nx;
        cnt    <= cnt_nx;
      end
    end
  end

endmodule

// File: rtl/lmsm_mem_stage.sv
// rtl/lmsm_mem_stage.sv - memory-access stage: M/W pipeline registers, data-memory drive, group tagging
module lmsm_mem_stage
  import risc_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [3:0]        opcode,
  input  logic [REG_W-1:0]  regr,
  input  logic [AW-1:0]     memloc,
  input  logic [DW-1:0]     st_data,
  input  logic              comp,
  input  logic              stall,
  output logic              in_ready,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DW-1:0]     wb_data,
  output logic              grp_done,
  output logic [CNT_W-1:0]  grp_cnt,
  output logic              seq_err,
  lmsm_mem_stage_if.master  dmem
);

  logic             accept;
  logic             tag_done;
  logic [CNT_W-1:0] tag_cnt;

  logic             m_valid;
  logic [3:0]       m_opcode;
  logic [REG_W-1:0] m_regr;
  logic [AW-1:0]    m_memloc;
  logic [DW-1:0]    m_st_data;
  logic             m_grp_done;
  logic [CNT_W-1:0] m_grp_cnt;

  logic             w_valid;
  logic             w_load;
  logic [REG_W-1:0] w_regr;
  logic [DW-1:0]    w_data;
  logic             w_grp_done;
  logic [CNT_W-1:0] w_grp_cnt;

  assign accept   = in_valid && !stall;
  assign in_ready = !stall;

  lmsm_grp_tracker u_grp (
    .clk      (clk),
    .rst_n    (rst_n),
    .accept   (accept),
    .opcode   (opcode),
    .comp     (comp),
    .tag_done (tag_done),
    .tag_cnt  (tag_cnt),
    .seq_err  (seq_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_opcode   <= '0;
      m_regr     <= '0;
      m_memloc   <= '0;
      m_st_data  <= '0;
      m_grp_done <= 1'b0;
      m_grp_cnt  <= '0;
    end else if (!stall) begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_opcode   <= opcode;
        m_regr     <= regr;
        m_memloc   <= memloc;
        m_st_data  <= st_data;
        m_grp_done <= tag_done;
        m_grp_cnt  <= tag_cnt;
      end
    end
  end

  // Stores commit only on the edge that moves M forward, so a stalled store writes once.
  assign dmem.dmem_addr  = m_memloc;
  assign dmem.dmem_wdata = m_st_data;
  assign dmem.dmem_we    = rst_n && m_valid && is_store(m_opcode) && !stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_valid    <= 1'b0;
      w_load     <= 1'b0;
      w_regr     <= '0;
      w_data     <= '0;
      w_grp_done <= 1'b0;
      w_grp_cnt  <= '0;
    end else if (!stall) begin
      w_valid    <= m_valid;
      w_load     <= m_valid && is_load(m_opcode);
      w_regr     <= m_regr;
      w_data     <= (m_valid && is_load(m_opcode)) ? dmem.dmem_rdata : '0;
      w_grp_done <= m_valid && m_grp_done;
      w_grp_cnt  <= (m_valid && m_grp_done) ? m_grp_cnt : '0;
    end
  end

  assign wb_valid = w_valid;
  assign wb_we    = w_valid && w_load;
  assign wb_reg   = w_regr;
  assign wb_data  = w_data;
  assign grp_done = w_grp_done;
  assign grp_cnt  = w_grp_cnt;

endmodule
